// File: rtl/fp_reduce_seq.sv
// fp_reduce_seq: sequences a stream of N single-precision operands through an
// external combinational fp_alu and folds them into one reduced result
// (sum, product, max or min) returned over a valid/ready result port.
module fp_reduce_seq #(
   parameter int N  = 8,
   parameter int CW = $clog2(N + 1)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          start,
   input  logic [1:0]    mode,
   output logic          busy,
   input  logic          in_valid,
   input  logic [31:0]   in_data,
   output logic          in_ready,
   output logic [31:0]   alu_a,
   output logic [31:0]   alu_b,
   output logic [1:0]    alu_op,
   input  logic [31:0]   alu_out,
   input  logic          alu_gt,
   output logic          res_valid,
   output logic [31:0]   res_data,
   input  logic          res_ready,
   output logic [CW-1:0] elem_cnt
);

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      LOAD  = 2'b01,
      ACCUM = 2'b10,
      DONE  = 2'b11
   } state_t;

   localparam logic [CW-1:0] N_CNT = CW'(N);

   state_t        state_q, state_d;
   logic [1:0]    mode_q,  mode_d;
   logic [31:0]   acc_q,   acc_d;
   logic [CW-1:0] cnt_q,   cnt_d;
   logic [CW-1:0] cnt_inc;
   logic          in_hs;

   // Handshake strobes and status outputs depend only on registered state,
   // so res_ready never reaches in_ready combinationally.
   assign in_ready  = (state_q == LOAD) || (state_q == ACCUM);
   assign busy      = (state_q != IDLE);
   assign res_valid = (state_q == DONE);
   assign res_data  = acc_q;
   assign elem_cnt  = cnt_q;
   assign in_hs     = in_valid && in_ready;
   assign cnt_inc   = cnt_q + CW'(1);

   // ALU operands are driven continuously; the consumer only trusts them in ACCUM.
   assign alu_a  = acc_q;
   assign alu_b  = in_data;
   assign alu_op = (mode_q == 2'b00) ? 2'b00 :
                   (mode_q == 2'b01) ? 2'b10 : 2'b11;

   // State and datapath registers; reset clears everything, aborting any reduction.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         mode_q  <= 2'b00;
         acc_q   <= 32'h0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         mode_q  <= mode_d;
         acc_q   <= acc_d;
         cnt_q   <= cnt_d;
      end
   end

   // Next-state and accumulator update; cycles without a handshake hold everything.
   always_comb begin
      state_d = state_q;
      mode_d  = mode_q;
      acc_d   = acc_q;
      cnt_d   = cnt_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               mode_d  = mode;
               cnt_d   = '0;
               state_d = LOAD;
            end
         end
         LOAD: begin
            // First element seeds the accumulator; the ALU result is ignored here.
            if (in_hs) begin
               acc_d   = in_data;
               cnt_d   = CW'(1);
               state_d = ACCUM;
            end
         end
         ACCUM: begin
            if (in_hs) begin
               cnt_d = cnt_inc;
               case (mode_q)
                  2'b00, 2'b01: acc_d = alu_out;
                  // alu_gt is low for equal values and NaNs: max takes the new
                  // operand, min keeps the accumulator.
                  2'b10:        acc_d = alu_gt ? acc_q : in_data;
                  default:      acc_d = alu_gt ? in_data : acc_q;
               endcase
               if (cnt_inc == N_CNT) begin
                  state_d = DONE;
               end
            end
         end
         DONE: begin
            if (res_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

endmodule

// File: tb/tb_fp_reduce_seq.sv
// Testbench for fp_reduce_seq: provides a behavioural fp_alu, drives directed
// and randomized reductions, and compares against a real-arithmetic reference.
module tb_fp_reduce_seq;

   localparam int N  = 8;
   localparam int CW = $clog2(N + 1);

   logic          clk;
   logic          rst_n;
   logic          start;
   logic [1:0]    mode;
   logic          busy;
   logic          in_valid;
   logic [31:0]   in_data;
   logic          in_ready;
   logic [31:0]   alu_a;
   logic [31:0]   alu_b;
   logic [1:0]    alu_op;
   logic [31:0]   alu_out;
   logic          alu_gt;
   logic          res_valid;
   logic [31:0]   res_data;
   logic          res_ready;
   logic [CW-1:0] elem_cnt;

   int n_vec = 0;
   int n_err = 0;

   logic [31:0] vec [N];

   fp_reduce_seq #(.N(N), .CW(CW)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .mode      (mode),
      .busy      (busy),
      .in_valid  (in_valid),
      .in_data   (in_data),
      .in_ready  (in_ready),
      .alu_a     (alu_a),
      .alu_b     (alu_b),
      .alu_op    (alu_op),
      .alu_out   (alu_out),
      .alu_gt    (alu_gt),
      .res_valid (res_valid),
      .res_data  (res_data),
      .res_ready (res_ready),
      .elem_cnt  (elem_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Decode a normal single-precision pattern to real (denormals read as zero).
   function automatic real f2r(input logic [31:0] b);
      real v;
      int  e;
      if (b[30:23] == 8'd0) return 0.0;
      v = 1.0 + real'(b[22:0]) / 8388608.0;
      e = int'(b[30:23]) - 127;
      while (e > 0) begin v = v * 2.0; e--; end
      while (e < 0) begin v = v / 2.0; e++; end
      return b[31] ? -v : v;
   endfunction

   // Encode a real to single precision (exact for the values used here).
   function automatic logic [31:0] r2f(input real r);
      real         a;
      int          e;
      logic        s;
      logic [31:0] m;
      if (r == 0.0) return 32'h0;
      s = (r < 0.0);
      a = s ? -r : r;
      e = 127;
      while (a >= 2.0 && e < 254) begin a = a / 2.0; e++; end
      while (a < 1.0 && e > 1)    begin a = a * 2.0; e--; end
      m = 32'($rtoi((a - 1.0) * 8388608.0));
      return {s, 8'(e), m[22:0]};
   endfunction

   // Behavioural fp_alu: 00 add, 10 multiply, 11 compare-only.
   always_comb begin
      alu_out = 32'h0;
      case (alu_op)
         2'b00:   alu_out = r2f(f2r(alu_a) + f2r(alu_b));
         2'b10:   alu_out = r2f(f2r(alu_a) * f2r(alu_b));
         default: alu_out = 32'h0;
      endcase
      alu_gt = (f2r(alu_a) > f2r(alu_b));
   end

   // Reference reduction of vec[] for a given mode.
   function automatic logic [31:0] ref_reduce(input logic [1:0] m);
      real acc;
      acc = f2r(vec[0]);
      for (int i = 1; i < N; i++) begin
         case (m)
            2'b00:   acc = acc + f2r(vec[i]);
            2'b01:   acc = acc * f2r(vec[i]);
            2'b10:   if (f2r(vec[i]) > acc) acc = f2r(vec[i]);
            default: if (f2r(vec[i]) < acc) acc = f2r(vec[i]);
         endcase
      end
      return r2f(acc);
   endfunction

   function automatic logic [31:0] rnd_val(input logic [1:0] m);
      int k;
      if (m == 2'b01) begin
         k = int'($urandom_range(0, 8)) - 4;
         return r2f(real'(k));
      end
      k = int'($urandom_range(0, 32)) - 16;
      return r2f(real'(k) / 2.0);
   endfunction

   // Runs one reduction from vec[]; called and returns at posedge+1.
   task automatic do_reduce(input logic [1:0] m, input bit bubble, input int pulse_at,
                            input int abort_after, output int lat, output logic [31:0] res,
                            output int cnt_seen, output bit tmo, output int op_bad,
                            output int bub_bad);
      int          idx;
      bit          hs;
      bit          phase;
      bit          chk_bub;
      logic [31:0] held;
      logic [1:0]  exp_op;
      exp_op = (m == 2'b00) ? 2'b00 : (m == 2'b01) ? 2'b10 : 2'b11;
      op_bad = 0; bub_bad = 0; tmo = 0; idx = 0; phase = 0;
      lat = 0; res = 32'h0; cnt_seen = 0;
      mode = m; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0; mode = 2'b00; lat = 1;
      while (!res_valid && !tmo) begin
         if (abort_after >= 0 && idx == abort_after) begin
            in_valid = 1'b0;
            return;
         end
         in_valid = (idx < N) && !(bubble && phase);
         in_data  = (idx < N) ? vec[idx] : 32'h0;
         if (lat == pulse_at) begin start = 1'b1; mode = 2'b01; end
         hs      = in_valid && in_ready;
         chk_bub = !in_valid && in_ready && (elem_cnt != 0);
         held    = alu_a;
         if (in_ready && elem_cnt != 0 && alu_op !== exp_op) op_bad++;
         @(posedge clk); #1;
         start = 1'b0; mode = 2'b00;
         lat++;
         if (hs) idx++;
         if (chk_bub && alu_a !== held) bub_bad++;
         phase = !phase;
         if (lat > 200) tmo = 1'b1;
      end
      in_valid = 1'b0;
      res      = res_data;
      cnt_seen = int'(elem_cnt);
   endtask

   task automatic finish_result();
      res_ready = 1'b1;
      @(posedge clk); #1;
      res_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; start = 1'b0; mode = 2'b00; in_valid = 1'b0;
      in_data = 32'h0; res_ready = 1'b0;
      #12;
      n_vec++; if (busy !== 1'b0)      begin n_err++; $display("FAIL reset_busy: got %b expected 0", busy); end
      n_vec++; if (in_ready !== 1'b0)  begin n_err++; $display("FAIL reset_in_ready: got %b expected 0", in_ready); end
      n_vec++; if (res_valid !== 1'b0) begin n_err++; $display("FAIL reset_res_valid: got %b expected 0", res_valid); end
      n_vec++; if (res_data !== 32'h0) begin n_err++; $display("FAIL reset_res_data: got %h expected 0", res_data); end
      n_vec++; if (elem_cnt !== '0)    begin n_err++; $display("FAIL reset_elem_cnt: got %0d expected 0", elem_cnt); end
      n_vec++; if (alu_a !== 32'h0)    begin n_err++; $display("FAIL reset_alu_a: got %h expected 0", alu_a); end
      n_vec++; if (alu_op !== 2'b00)   begin n_err++; $display("FAIL reset_alu_op: got %b expected 00", alu_op); end
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      $display("test_reset done");
   endtask

   task automatic test_sum_no_stall();
      int lat, cnt, opb, bub; bit tmo; logic [31:0] res;
      for (int i = 0; i < N; i++) vec[i] = r2f(real'(i + 1));
      do_reduce(2'b00, 1'b0, -1, -1, lat, res, cnt, tmo, opb, bub);
      n_vec++; if (tmo)              begin n_err++; $display("FAIL sum_timeout: no res_valid within bound"); end
      n_vec++; if (lat != N + 1)     begin n_err++; $display("FAIL sum_latency: got %0d expected %0d", lat, N + 1); end
      n_vec++; if (res !== 32'h42100000) begin n_err++; $display("FAIL sum_result: got %h expected 42100000", res); end
      n_vec++; if (cnt != N)         begin n_err++; $display("FAIL sum_elem_cnt: got %0d expected %0d", cnt, N); end
      n_vec++; if (opb != 0)         begin n_err++; $display("FAIL sum_alu_op: %0d bad cycles expected 0", opb); end
      finish_result();
      n_vec++; if (busy !== 1'b0)    begin n_err++; $display("FAIL sum_return_idle: busy %b expected 0", busy); end
      $display("test_sum_no_stall res=%h lat=%0d", res, lat);
   endtask

   task automatic test_product_bubbles();
      int lat, cnt, opb, bub; bit tmo; logic [31:0] res;
      for (int i = 0; i < N; i++) vec[i] = 32'h40000000;
      do_reduce(2'b01, 1'b1, -1, -1, lat, res, cnt, tmo, opb, bub);
      n_vec++; if (tmo)              begin n_err++; $display("FAIL prod_timeout: no res_valid within bound"); end
      n_vec++; if (lat != 2 * N)     begin n_err++; $display("FAIL prod_latency: got %0d expected %0d", lat, 2 * N); end
      n_vec++; if (res !== 32'h43800000) begin n_err++; $display("FAIL prod_result: got %h expected 43800000", res); end
      n_vec++; if (bub != 0)         begin n_err++; $display("FAIL prod_bubble_hold: %0d changed cycles expected 0", bub); end
      n_vec++; if (opb != 0)         begin n_err++; $display("FAIL prod_alu_op: %0d bad cycles expected 0", opb); end
      finish_result();
      $display("test_product_bubbles res=%h lat=%0d", res, lat);
   endtask

   task automatic test_max_min();
      int lat, cnt, opb, bub; bit tmo; logic [31:0] res;
      logic [31:0] tbl [N];
      tbl = '{32'hC0400000, 32'h40B00000, 32'h3F800000, 32'h3F800000,
              32'hC0400000, 32'h40000000, 32'h3F000000, 32'h40B00000};
      for (int i = 0; i < N; i++) vec[i] = tbl[i];
      do_reduce(2'b10, 1'b0, -1, -1, lat, res, cnt, tmo, opb, bub);
      n_vec++; if (tmo || res !== 32'h40B00000) begin n_err++; $display("FAIL max_result: got %h expected 40b00000 (timeout %0b)", res, tmo); end
      n_vec++; if (opb != 0) begin n_err++; $display("FAIL max_alu_op: %0d bad cycles expected 0", opb); end
      finish_result();
      $display("test_max res=%h", res);
      do_reduce(2'b11, 1'b0, -1, -1, lat, res, cnt, tmo, opb, bub);
      n_vec++; if (tmo || res !== 32'hC0400000) begin n_err++; $display("FAIL min_result: got %h expected c0400000 (timeout %0b)", res, tmo); end
      n_vec++; if (opb != 0) begin n_err++; $display("FAIL min_alu_op: %0d bad cycles expected 0", opb); end
      finish_result();
      $display("test_min res=%h", res);
   endtask

   task automatic test_backpressure();
      int lat, cnt, opb, bub; bit tmo; logic [31:0] res, exp_res;
      for (int i = 0; i < N; i++) vec[i] = rnd_val(2'b00);
      exp_res = ref_reduce(2'b00);
      do_reduce(2'b00, 1'b0, -1, -1, lat, res, cnt, tmo, opb, bub);
      n_vec++; if (tmo) begin n_err++; $display("FAIL bp_timeout: no res_valid within bound"); end
      for (int k = 0; k < 3; k++) begin
         n_vec++; if (res_valid !== 1'b1)  begin n_err++; $display("FAIL bp_res_valid: cycle %0d got %b expected 1", k, res_valid); end
         n_vec++; if (res_data !== exp_res) begin n_err++; $display("FAIL bp_res_data: cycle %0d got %h expected %h", k, res_data, exp_res); end
         n_vec++; if (in_ready !== 1'b0)   begin n_err++; $display("FAIL bp_in_ready: cycle %0d got %b expected 0", k, in_ready); end
         if (k == 1) begin start = 1'b1; mode = 2'b01; end
         @(posedge clk); #1;
         start = 1'b0; mode = 2'b00;
      end
      n_vec++; if (alu_op !== 2'b00) begin n_err++; $display("FAIL bp_start_ignored: alu_op %b expected 00", alu_op); end
      finish_result();
      n_vec++; if (busy !== 1'b0 || res_valid !== 1'b0) begin n_err++; $display("FAIL bp_release_idle: busy %b res_valid %b expected 0 0", busy, res_valid); end
      $display("test_backpressure res=%h exp=%h", res, exp_res);
   endtask

   task automatic test_back_to_back();
      int lat, cnt, opb, bub; bit tmo; logic [31:0] res, exp_res;
      for (int i = 0; i < N; i++) vec[i] = rnd_val(2'b11);
      exp_res = ref_reduce(2'b11);
      do_reduce(2'b11, 1'b0, -1, -1, lat, res, cnt, tmo, opb, bub);
      n_vec++; if (tmo || res !== exp_res) begin n_err++; $display("FAIL b2b_result: got %h expected %h (timeout %0b)", res, exp_res, tmo); end
      n_vec++; if (lat != N + 1) begin n_err++; $display("FAIL b2b_latency: got %0d expected %0d", lat, N + 1); end
      finish_result();
      $display("test_back_to_back res=%h exp=%h", res, exp_res);
   endtask

   task automatic test_start_while_busy();
      int lat, cnt, opb, bub; bit tmo; logic [31:0] res, exp_res;
      for (int i = 0; i < N; i++) vec[i] = rnd_val(2'b00);
      exp_res = ref_reduce(2'b00);
      do_reduce(2'b00, 1'b0, 4, -1, lat, res, cnt, tmo, opb, bub);
      n_vec++; if (tmo || res !== exp_res) begin n_err++; $display("FAIL busy_start_result: got %h expected %h (timeout %0b)", res, exp_res, tmo); end
      n_vec++; if (opb != 0) begin n_err++; $display("FAIL busy_start_alu_op: %0d bad cycles expected 0", opb); end
      finish_result();
      $display("test_start_while_busy res=%h exp=%h", res, exp_res);
   endtask

   task automatic test_reset_mid();
      int lat, cnt, opb, bub; bit tmo; logic [31:0] res;
      for (int i = 0; i < N; i++) vec[i] = 32'h3F800000;
      do_reduce(2'b00, 1'b0, -1, 4, lat, res, cnt, tmo, opb, bub);
      #3 rst_n = 1'b0;
      #1;
      n_vec++; if (busy !== 1'b0 || in_ready !== 1'b0 || res_valid !== 1'b0)
         begin n_err++; $display("FAIL mid_reset_ctrl: busy %b in_ready %b res_valid %b expected 000", busy, in_ready, res_valid); end
      n_vec++; if (res_data !== 32'h0 || alu_a !== 32'h0)
         begin n_err++; $display("FAIL mid_reset_data: res_data %h alu_a %h expected 0 0", res_data, alu_a); end
      n_vec++; if (elem_cnt !== '0 || alu_op !== 2'b00)
         begin n_err++; $display("FAIL mid_reset_cnt: elem_cnt %0d alu_op %b expected 0 00", elem_cnt, alu_op); end
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      do_reduce(2'b00, 1'b0, -1, -1, lat, res, cnt, tmo, opb, bub);
      n_vec++; if (tmo || res !== 32'h41000000) begin n_err++; $display("FAIL mid_reset_fresh: got %h expected 41000000 (timeout %0b)", res, tmo); end
      n_vec++; if (cnt != N) begin n_err++; $display("FAIL mid_reset_elem_cnt: got %0d expected %0d", cnt, N); end
      finish_result();
      $display("test_reset_mid res=%h", res);
   endtask

   task automatic test_random();
      int lat, cnt, opb, bub; bit tmo; logic [31:0] res, exp_res;
      logic [1:0] m;
      bit b;
      for (int r = 0; r < 8; r++) begin
         m = 2'($urandom_range(0, 3));
         b = 1'($urandom_range(0, 1));
         for (int i = 0; i < N; i++) vec[i] = rnd_val(m);
         exp_res = ref_reduce(m);
         do_reduce(m, b, -1, -1, lat, res, cnt, tmo, opb, bub);
         n_vec++; if (tmo || res !== exp_res) begin n_err++; $display("FAIL rand_result: run %0d mode %b got %h expected %h (timeout %0b)", r, m, res, exp_res, tmo); end
         n_vec++; if (opb != 0 || bub != 0) begin n_err++; $display("FAIL rand_alu_hold: run %0d op_bad %0d bubble_bad %0d expected 0 0", r, opb, bub); end
         finish_result();
         $display("test_random run %0d mode %b bubbles %0b res=%h exp=%h", r, m, b, res, exp_res);
      end
   endtask

   initial begin
      test_reset();
      test_sum_no_stall();
      test_product_bubbles();
      test_max_min();
      test_backpressure();
      test_back_to_back();
      test_start_while_busy();
      test_reset_mid();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/fp_reduce_seq.md
# fp_reduce_seq

Sequencing stage that sits directly upstream of the combinational `fp_alu`. It accepts a stream of N single-precision operands and drives `fp_alu` one element per handshake, folding them into an accumulator. It returns one reduced result (sum, product, max or min) through a valid/ready result port. The ALU itself stays a separate instance; this block owns its A/B/op inputs and consumes its out/gt outputs in the same cycle.

## Interface
- `N`, default 8: elements per reduction; legal range N ≥ 2.
- `CW`, default $clog2(N+1): element-counter width.

- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `start`  in  1  one-cycle pulse; begins a reduction; honoured only in IDLE.
- `mode`  in  2  sampled with `start`: 00 sum, 01 product, 10 max, 11 min.
- `busy`  out  1  high in any state other than IDLE.
- `in_valid`  in  1  operand valid.
- `in_data`  in  32  IEEE-754 single operand.
- `in_ready`  out  1  high only in LOAD and ACCUM.
- `alu_a`  out  32  to `fp_alu.A`; equals `acc`.
- `alu_b`  out  32  to `fp_alu.B`; equals `in_data`.
- `alu_op`  out  2  to `fp_alu.op`: sum→00, product→10, max/min→11.
- `alu_out`  in  32  from `fp_alu.out`.
- `alu_gt`  in  1  from `fp_alu.gt`; high when A > B.
- `res_valid`  out  1  result valid; high only in DONE.
- `res_data`  out  32  reduced value; equals `acc`.
- `res_ready`  in  1  result consumer ready.
- `elem_cnt`  out  CW  elements accepted in the current reduction.

## Operation
- States: IDLE, LOAD, ACCUM, DONE.
- Registers: `state`, `mode_q`, `acc` (32 b), `cnt` (CW b).
- IDLE:
  - On `start`: `mode_q`←`mode`, `cnt`←0, go to LOAD.
  - `start` in any other state is ignored and does not change `mode_q`.
- LOAD:
  - On handshake (`in_valid && in_ready`): `acc`←`in_data`, `cnt`←1, go to ACCUM.
  - No ALU result is used in LOAD.
- ACCUM, on handshake, `cnt`←`cnt`+1 and `acc` updates as follows:
  - sum or product: `acc`←`alu_out`.
  - max: `acc`←`alu_gt` ? `acc` : `in_data`.
  - min: `acc`←`alu_gt` ? `in_data` : `acc`.
  - Equal values and NaNs: `alu_gt`=0, so max takes `in_data` and min keeps `acc`.
- ACCUM exit: on the handshake that makes `cnt`==N, go to DONE.
- DONE: hold `res_valid`=1 and a stable `res_data` until `res_ready`; on `res_valid && res_ready`, go to IDLE.
- Cycles with `in_valid`=0 hold all state.
- `in_data` is not checked for NaN/Inf; arithmetic semantics belong to `fp_alu`.
- `alu_a`, `alu_b` and `alu_op` are driven continuously from `acc`, `in_data` and `mode_q`, including in IDLE. Downstream must ignore them outside ACCUM.

## Timing
- Reset (async assert, sync release) puts every register to 0:
  - state=IDLE, `acc`=0, `mode_q`=00, `cnt`=0.
  - Outputs: `busy`=0, `in_ready`=0, `res_valid`=0, `res_data`=0, `elem_cnt`=0, `alu_a`=0, `alu_op`=00.
- `start` sampled at edge T → `in_ready`=1 in cycle T+1.
- With `in_valid` held high, handshakes occur in cycles T+1..T+N and `res_valid` rises in cycle T+N+1.
- Minimum start-to-result latency is N+1 cycles.
- The result handshake in cycle R returns to IDLE in R+1. A `start` in R+1 is accepted, so there is one idle bubble minimum between reductions.
- There is no combinational path from `res_ready` to `in_ready`. `in_ready` depends only on state.
- Reset asserted mid-reduction (any state) aborts immediately. The partial `acc` is discarded and no `res_valid` is produced.
- `elem_cnt` saturates at N in DONE and resets to 0 on the next `start`.

## Test plan
- **Sum, no stalls.** N=8, mode 00, inputs 1.0..8.0 (0x3F800000…0x41000000) → `res_valid` exactly 9 cycles after `start`, `res_data`=0x42100000 (36.0), `elem_cnt`=8.
- **Product with input bubbles.** Mode 01, eight 2.0 (0x40000000), `in_valid` low every other cycle → `res_data`=0x43800000 (256.0); `acc` unchanged in bubble cycles; latency 16 cycles.
- **Max and min.**
  - Mode 10 on {−3.0 (0xC0400000), 5.5 (0x40B00000), 1.0, 1.0, −3.0, 2.0, 0.5, 5.5} → 0x40B00000.
  - Same data with mode 11 → 0xC0400000.
  - Check `alu_op`=11 during ACCUM in both cases.
- **Result backpressure.** Hold `res_ready` low for 3 cycles in DONE → `res_valid` and `res_data` stable, `in_ready`=0, and a second `start` is ignored. Release → IDLE the next cycle.
- **Start while busy.** Pulse `start` with mode 01 during a mode-00 ACCUM → mode stays sum and the final sum is correct.
- **Reset mid-operation.** Drop `rst_n` after 4 accepted elements → all outputs 0 asynchronously. After release, a fresh reduction of eight 1.0 gives 0x41000000 (8.0).
